// File: rtl/controller_poller.sv
// controller_poller: latches and clocks two serial game pads, deserializes 8 active-low buttons each
module controller_poller #(
  parameter int HALF_PERIOD = 6
) (
  input  logic       clk_12_5875,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       controller_clk_out,
  output logic       controller_latch,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
  output logic [7:0] controller_1_buttons_out,
  output logic [7:0] controller_2_buttons_out
);
  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_HI, CLK_LO, DONE} state_t;
  localparam logic [7:0] H_LAST = 8'(HALF_PERIOD - 1);
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bits, bits_n;
  logic [6:0] sr1, sr2;
  logic       hp_end, smp;
  // Next-state: every phase is a whole number of half-periods; LATCH spans two of them
  always_comb begin
    hp_end = cnt == H_LAST;
    state_n = state;
    cnt_n = hp_end ? 8'd0 : cnt + 8'd1;
    bits_n = bits;
    smp = 1'b0;
    case (state)
      IDLE, DONE: begin
        cnt_n = 8'd0;
        bits_n = 3'd0;
        state_n = start ? LATCH : IDLE;
      end
      LATCH: if (hp_end) begin
        bits_n = bits == 3'd1 ? 3'd0 : bits + 3'd1;
        state_n = bits == 3'd1 ? GAP : LATCH;
      end
      GAP: if (hp_end) begin
        smp = 1'b1;
        state_n = CLK_HI;
      end
      CLK_HI: state_n = hp_end ? CLK_LO : CLK_HI;
      CLK_LO: if (hp_end) begin
        smp = 1'b1;
        bits_n = bits + 3'd1;
        state_n = bits == 3'd6 ? DONE : CLK_HI;
      end
      default: state_n = IDLE;
    endcase
  end
  // State, shift registers and registered outputs; the eighth sample goes straight into the button bytes
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      bits <= 3'd0;
      sr1 <= 7'd0;
      sr2 <= 7'd0;
      busy <= 1'b0;
      done <= 1'b0;
      controller_clk_out <= 1'b0;
      controller_latch <= 1'b0;
      controller_1_buttons_out <= 8'd0;
      controller_2_buttons_out <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      if (smp) begin
        sr1 <= {sr1[5:0], controller_1_data_in_B};
        sr2 <= {sr2[5:0], controller_2_data_in_B};
      end
      if (smp && state_n == DONE) begin
        controller_1_buttons_out <= ~{sr1, controller_1_data_in_B};
        controller_2_buttons_out <= ~{sr2, controller_2_data_in_B};
      end
      busy <= state_n inside {LATCH, GAP, CLK_HI, CLK_LO};
      done <= state_n == DONE;
      controller_clk_out <= state_n == CLK_HI;
      controller_latch <= state_n == LATCH;
    end
  end
endmodule

// File: tb/tb_controller_poller.sv
// tb_controller_poller: directed checks of poll timing, button capture, start filtering and reset abort
module tb_controller_poller;
  logic       clk_12_5875 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, controller_clk_out, controller_latch;
  logic       controller_1_data_in_B, controller_2_data_in_B;
  logic [7:0] controller_1_buttons_out, controller_2_buttons_out;
  logic [7:0] m1 = 8'd0, m2 = 8'd0, p1 = 8'd0, p2 = 8'd0;
  logic [7:0] e1 = 8'd0, e2 = 8'd0;
  logic       clk_prev = 1'b0, frc = 1'b0, fval = 1'b1;
  int         pass_n = 0, fail_n = 0, tot = 0;

  controller_poller dut (
    .clk_12_5875(clk_12_5875),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .controller_clk_out(controller_clk_out),
    .controller_latch(controller_latch),
    .controller_1_data_in_B(controller_1_data_in_B),
    .controller_2_data_in_B(controller_2_data_in_B),
    .controller_1_buttons_out(controller_1_buttons_out),
    .controller_2_buttons_out(controller_2_buttons_out)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  // Pad model: parallel load while latch is high, shift on each rising pad clock
  always @(posedge clk_12_5875) begin
    if (controller_latch) begin
      p1 <= m1;
      p2 <= m2;
    end else if (controller_clk_out && !clk_prev) begin
      p1 <= p1 << 1;
      p2 <= p2 << 1;
    end
    clk_prev <= controller_clk_out;
  end
  assign controller_1_data_in_B = frc ? fval : ~p1[7];
  assign controller_2_data_in_B = frc ? fval : ~p2[7];

  task automatic step;
    @(posedge clk_12_5875);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tot++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, done, controller_clk_out, controller_latch}, 16'h0);
    chk({tag, "_btn"}, {controller_1_buttons_out, controller_2_buttons_out}, {e1, e2});
  endtask

  // Called in cycle 0 with start already high; returns in cycle 103
  task automatic run_poll(input logic [7:0] r1, input logic [7:0] r2, input int extra,
                          input bit chain, input logic [7:0] n1, input logic [7:0] n2);
    for (int c = 1; c <= 103; c++) begin
      step;
      start = chain || (c == extra);
      if (chain && c == 103) begin
        m1 = n1;
        m2 = n2;
      end
      if (c == 103) begin
        e1 = r1;
        e2 = r2;
      end
      chk("latch", {15'd0, controller_latch}, {15'd0, c <= 12});
      chk("clk", {15'd0, controller_clk_out}, {15'd0, c >= 19 && c <= 102 && ((c - 19) % 12) < 6});
      chk("busy", {15'd0, busy}, {15'd0, c <= 102});
      chk("done", {15'd0, done}, {15'd0, c == 103});
      chk("buttons", {controller_1_buttons_out, controller_2_buttons_out}, {e1, e2});
    end
  endtask

  initial begin
    frc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fval = 1'($urandom);
      start = 1'($urandom);
      step;
    end
    chk_idle("reset");
    rst = 1'b0;
    start = 1'b0;
    frc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step;
      chk_idle("idle");
    end
    m1 = 8'hA5;
    m2 = 8'h3C;
    start = 1'b1;
    run_poll(8'hA5, 8'h3C, 0, 1'b0, 8'h00, 8'h00);
    m1 = 8'h5A;
    m2 = 8'hC3;
    start = 1'b1;
    run_poll(8'h5A, 8'hC3, 50, 1'b0, 8'h00, 8'h00);
    m1 = 8'hA5;
    m2 = 8'h3C;
    start = 1'b1;
    run_poll(8'hA5, 8'h3C, 0, 1'b1, 8'hFF, 8'h00);
    run_poll(8'hFF, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    m1 = 8'h12;
    m2 = 8'h34;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step;
      start = 1'b0;
      rst = c == 60;
    end
    step;
    rst = 1'b0;
    e1 = 8'h00;
    e2 = 8'h00;
    chk_idle("abort");
    for (int i = 0; i < 60; i++) begin
      step;
      chk_idle("post_abort");
    end
    m1 = 8'h81;
    m2 = 8'h7E;
    start = 1'b1;
    run_poll(8'h81, 8'h7E, 0, 1'b0, 8'h00, 8'h00);
    frc = 1'b1;
    fval = 1'b1;
    start = 1'b1;
    run_poll(8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    fval = 1'b0;
    start = 1'b1;
    run_poll(8'hFF, 8'hFF, 0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      fval = 1'($urandom);
      step;
      chk_idle("hold");
    end
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule

// File: doc/controller_poller.md
Name: controller_poller

Overview:
- Host-side initiator for the serial game-controller interface. It produces the latch and shift-clock pulses and reads both controllers' active-low serial data in parallel.
- It deserializes 8 buttons per controller and presents stable, active-high button bytes to the memory-mapped controller registers.
- Sits inside top_m between the pad pins and the CPU bus. A poll is normally triggered once per frame from vsync logic.

Parameters:
- HALF_PERIOD, 6, system clocks per controller-clock half-phase (1..255). Default gives ~1.05 MHz pad clock from 12.5875 MHz.

Ports:
- clk_12_5875  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle poll request; accepted only when idle
- busy  output  1  high from the cycle after start is accepted through the final sample cycle
- done  output  1  one-cycle pulse when new button bytes become valid
- controller_clk_out  output  1  shift clock to both pads; registered
- controller_latch  output  1  parallel-load strobe to both pads; registered
- controller_1_data_in_B  input  1  pad 1 serial data, active-low (0 = pressed)
- controller_2_data_in_B  input  1  pad 2 serial data, active-low
- controller_1_buttons_out  output  8  pad 1 buttons, active-high; bit7 = first bit shifted
- controller_2_buttons_out  output  8  pad 2 buttons, active-high

Behaviour:
- Reset: all outputs are 0, including both button bytes; FSM returns to IDLE; the half-period counter and bit counter clear.
- Reset mid-poll: takes effect on the next edge, aborts the poll, and suppresses done. Button bytes go to 0.
- FSM states: IDLE, LATCH, GAP, CLK_HI, CLK_LO, DONE.
- Timing is relative to cycle 0, the cycle in which start is sampled high in IDLE (H = HALF_PERIOD):
  - LATCH: controller_latch = 1 for cycles 1..2H.
  - GAP: latch = 0 and clk = 0 for cycles 2H+1..3H. At the end of cycle 3H, sample bit 7 from both data_in_B lines into the shift registers.
  - For n = 1..7:
    - CLK_HI: controller_clk_out = 1 for cycles 3H+2H(n-1)+1 .. 3H+2H(n-1)+H.
    - CLK_LO: controller_clk_out = 0 for the next H cycles.
    - Sample bit 7-n on the last CLK_LO cycle, i.e. cycle 3H+2Hn.
  - The last sample is taken at cycle 17H.
  - DONE (cycle 17H+1): both button bytes update simultaneously to the inverted shift-register contents (~serial). done = 1 and busy = 0. FSM is idle-equivalent, so start is accepted in this cycle for back-to-back polls.
  - Default H=6: done at cycle 103.
- Sampling and data path:
  - Data is sampled directly into the shift registers; the pads are synchronous to our own clock, so no synchronizer is used.
  - Shift direction: new bit enters at bit 0 and the register shifts left, so the first bit lands in bit 7 after 8 samples.
- Button bytes change only in the DONE cycle or on reset; they hold between polls.
- Start handling:
  - start while busy (cycles 1..17H) is ignored. It is not queued and does not extend the poll.
  - start held high continuously produces consecutive polls, with done every 17H+1 cycles.
- Outputs are glitch-free:
  - latch and clk are never high in the same cycle.
  - clk_out is low whenever latch is high and throughout GAP.
- Counter widths: the half-period counter is 8 bits; the bit counter is 3 bits. Wrap is never reached within legal parameter values.

Test Plan:
- Reset 3 cycles with random inputs -> all outputs 0. After release with start low for 200 cycles, outputs stay 0.
- Pad models loaded with pressed masks 8'hA5 / 8'h3C, start pulse at cycle 0:
  - latch high cycles 1..12;
  - exactly 7 clk pulses, each 6 cycles wide, first rising at cycle 19;
  - done only at cycle 103, with buttons_out 8'hA5 / 8'h3C;
  - busy high cycles 1..102.
- Repeat the poll with a second start asserted at cycle 50 -> ignored; a single done at cycle 103; values correct.
- start held high through cycle 103 -> second poll's latch rises at cycle 104; done again at 206 with updated masks 8'hFF / 8'h00.
- rst asserted at cycle 60 of a poll -> latch and clk are 0 and busy is 0 from cycle 61; no done; buttons_out 8'h00. A fresh poll afterwards returns the correct masks.
- data_in_B lines held 1 (no pads connected) -> buttons 8'h00. Held 0 -> 8'hFF. Between polls, changing data_in_B never alters buttons_out.
